// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - op stream, imem write port and status bundle for instr_encoder
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [4:0]        op_operand;
    logic              op_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [8:0]        imem_wdata;
    logic              done;
    logic              err_illegal;
    logic              err_overflow;
    logic [ADDR_W:0]   prog_len;

    modport master (
        output start, op_valid, op_code, op_operand, op_last,
        input  op_ready, imem_we, imem_addr, imem_wdata,
        input  done, err_illegal, err_overflow, prog_len
    );

    modport slave (
        input  start, op_valid, op_code, op_operand, op_last,
        output op_ready, imem_we, imem_addr, imem_wdata,
        output done, err_illegal, err_overflow, prog_len
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - legality check and loader of 9-bit MIDS words into instruction memory
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);
    localparam logic [8:0]      HALT_WORD = 9'b101100000;
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPEND, S_DONE, S_ERR} state_t;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_wdata;
    logic              r_done;
    logic              r_err_ill;
    logic              r_err_ovf;
    logic [ADDR_W:0]   r_len;

    logic              w_accept;
    logic              w_legal;
    logic              w_room;
    logic [8:0]        w_word;

    // Anything not listed is register-form and needs a register-sized operand.
    function automatic logic legal_op(input logic [3:0] code, input logic [4:0] opnd);
        case (code)
            4'b0100, 4'b1010, 4'b1101, 4'b1111: legal_op = 1'b1;
            4'b1011:                            legal_op = (opnd == 5'd0);
            4'b0111:                            legal_op = 1'b0;
            default:                            legal_op = ~opnd[4];
        endcase
    endfunction

    assign w_word   = {bus.op_code, bus.op_operand};
    assign w_legal  = legal_op(bus.op_code, bus.op_operand);
    assign w_room   = (r_len < DEPTH_C);
    assign w_accept = bus.op_valid & bus.op_ready;

    assign bus.op_ready     = (r_state == S_LOAD);
    assign bus.imem_we      = r_we;
    assign bus.imem_addr    = r_addr;
    assign bus.imem_wdata   = r_wdata;
    assign bus.done         = r_done;
    assign bus.err_illegal  = r_err_ill;
    assign bus.err_overflow = r_err_ovf;
    assign bus.prog_len     = r_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
            r_len     <= '0;
        end else begin
            r_we <= 1'b0;
            if (bus.start) begin
                // A handshake coinciding with start is dropped.
                r_state   <= S_LOAD;
                r_len     <= '0;
                r_done    <= 1'b0;
                r_err_ill <= 1'b0;
                r_err_ovf <= 1'b0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            if (!w_legal) begin
                                r_err_ill <= 1'b1;
                                r_state   <= S_ERR;
                            end else if (!w_room) begin
                                r_err_ovf <= 1'b1;
                                r_state   <= S_ERR;
                            end else begin
                                r_we    <= 1'b1;
                                r_addr  <= r_len[ADDR_W-1:0];
                                r_wdata <= w_word;
                                r_len   <= r_len + ONE;
                                if (bus.op_last) begin
                                    if (w_word == HALT_WORD) begin
                                        r_state <= S_DONE;
                                        r_done  <= 1'b1;
                                    end else begin
                                        r_state <= S_APPEND;
                                    end
                                end
                            end
                        end
                    end
                    S_APPEND: begin
                        if (w_room) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_len[ADDR_W-1:0];
                            r_wdata <= HALT_WORD;
                            r_len   <= r_len + ONE;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_err_ovf <= 1'b1;
                            r_state   <= S_ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - lockstep model check of two instr_encoder depths
module tb_instr_encoder;
    localparam int AW0 = 8;
    localparam int D0  = 256;
    localparam int AW1 = 3;
    localparam int D1  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_last = 1'b0;
    logic [3:0] op_code = 4'd0;
    logic [4:0] op_operand = 5'd0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW0)) if0 ();
    instr_encoder_if #(.ADDR_W(AW1)) if1 ();

    assign if0.start = start;      assign if1.start = start;
    assign if0.op_valid = op_valid; assign if1.op_valid = op_valid;
    assign if0.op_code = op_code;   assign if1.op_code = op_code;
    assign if0.op_operand = op_operand; assign if1.op_operand = op_operand;
    assign if0.op_last = op_last;   assign if1.op_last = op_last;

    instr_encoder #(.ADDR_W(AW0), .DEPTH(D0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    instr_encoder #(.ADDR_W(AW1), .DEPTH(D1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {P_IDLE, P_LOAD, P_APPEND, P_DONE, P_ERR} phase_t;
    phase_t m_ph [2];
    int     m_len [2];
    bit     m_we [2];
    int     m_addr [2];
    int     m_word [2];
    bit     m_done [2];
    bit     m_ill [2];
    bit     m_ovf [2];
    int     depth [2] = '{D0, D1};
    int     mem [2][256];
    int     wr_cnt [2];
    // 0 register-form, 1 immediate, 2 halt, 3 never legal
    int     kind_tab [16] = '{0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 2, 0, 1, 0, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input int code, input int opnd);
        case (kind_tab[code])
            0:       return opnd < 16;
            1:       return 1'b1;
            2:       return opnd == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = P_IDLE; m_len[d] = 0; m_we[d] = 0; m_done[d] = 0;
            m_ill[d] = 0; m_ovf[d] = 0;
        end
    endtask

    task automatic emit(input int d, input int w);
        m_we[d] = 1; m_addr[d] = m_len[d]; m_word[d] = w; m_len[d]++;
    endtask

    task automatic model_step(input int d);
        m_we[d] = 0;
        if (start) begin
            m_ph[d] = P_LOAD; m_len[d] = 0; m_done[d] = 0; m_ill[d] = 0; m_ovf[d] = 0;
        end else if (m_ph[d] == P_LOAD && op_valid) begin
            if (!is_legal(op_code, op_operand)) begin
                m_ill[d] = 1; m_ph[d] = P_ERR;
            end else if (m_len[d] == depth[d]) begin
                m_ovf[d] = 1; m_ph[d] = P_ERR;
            end else begin
                emit(d, op_code * 32 + op_operand);
                if (op_last) begin
                    if (op_code == 4'd11) begin m_ph[d] = P_DONE; m_done[d] = 1; end
                    else m_ph[d] = P_APPEND;
                end
            end
        end else if (m_ph[d] == P_APPEND) begin
            if (m_len[d] < depth[d]) begin
                emit(d, 9'b101100000); m_ph[d] = P_DONE; m_done[d] = 1;
            end else begin
                m_ovf[d] = 1; m_ph[d] = P_ERR;
            end
        end
    endtask

    task automatic compare(input int d);
        logic we, rdy, dn, ill, ovf;
        logic [31:0] addr, wd, len;
        if (d == 0) begin
            we = if0.imem_we; addr = 32'(if0.imem_addr); wd = 32'(if0.imem_wdata);
            rdy = if0.op_ready; dn = if0.done; ill = if0.err_illegal; ovf = if0.err_overflow;
            len = 32'(if0.prog_len);
        end else begin
            we = if1.imem_we; addr = 32'(if1.imem_addr); wd = 32'(if1.imem_wdata);
            rdy = if1.op_ready; dn = if1.done; ill = if1.err_illegal; ovf = if1.err_overflow;
            len = 32'(if1.prog_len);
        end
        check($sformatf("d%0d imem_we", d), 32'(we), 32'(m_we[d]));
        if (m_we[d]) begin
            check($sformatf("d%0d imem_addr", d), addr, m_addr[d]);
            check($sformatf("d%0d imem_wdata", d), wd, m_word[d]);
        end
        check($sformatf("d%0d op_ready", d), 32'(rdy), 32'(m_ph[d] == P_LOAD));
        check($sformatf("d%0d done", d), 32'(dn), 32'(m_done[d]));
        check($sformatf("d%0d err_illegal", d), 32'(ill), 32'(m_ill[d]));
        check($sformatf("d%0d err_overflow", d), 32'(ovf), 32'(m_ovf[d]));
        check($sformatf("d%0d prog_len", d), len, m_len[d]);
        if (we === 1'b1) begin
            mem[d][addr[7:0]] = wd;
            wr_cnt[d]++;
        end
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic clear_mem();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0;
            for (int a = 0; a < 256; a++) mem[d][a] = -1;
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [4:0] o, input logic l);
        op_valid = 1'b1; op_code = c; op_operand = o; op_last = l;
        step();
        op_valid = 1'b0; op_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear_mem();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare(0);
        compare(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Explicit program ending in halt: no append.
        pulse_start();
        clear_mem();
        send(4'b0000, 5'b00011, 1'b0);
        send(4'b0100, 5'b11111, 1'b0);
        send(4'b1011, 5'b00000, 1'b1);
        repeat (2) step();
        check("t1 mem0", mem[0][0], 32'h003);
        check("t1 mem1", mem[0][1], 32'h09F);
        check("t1 mem2", mem[0][2], 32'h160);
        check("t1 writes", wr_cnt[0], 3);
        check("t1 done", 32'(if0.done), 1);
        check("t1 len", 32'(if0.prog_len), 3);

        // Non-halt last op: halt appended.
        pulse_start();
        clear_mem();
        send(4'b0001, 5'b00010, 1'b1);
        check("t2 append ready", 32'(if0.op_ready), 0);
        repeat (2) step();
        check("t2 mem0", mem[0][0], 32'h022);
        check("t2 mem1", mem[0][1], 32'h160);
        check("t2 len", 32'(if0.prog_len), 2);
        check("t2 done", 32'(if0.done), 1);

        // Illegal ops.
        pulse_start();
        clear_mem();
        send(4'b0111, 5'b00000, 1'b0);
        step();
        check("t3 ill 0111", 32'(if0.err_illegal), 1);
        check("t3 no write", wr_cnt[0], 0);
        pulse_start();
        send(4'b0110, 5'b10000, 1'b0);
        step();
        check("t3 ill mov", 32'(if0.err_illegal), 1);
        pulse_start();
        check("t3 cleared", 32'(if0.err_illegal), 0);

        // Depth-4 overflow via append, then via a fifth op.
        clear_mem();
        for (int i = 0; i < 4; i++) send(4'b0000, 5'(i), i == 3);
        repeat (2) step();
        check("t4 writes", wr_cnt[1], 4);
        check("t4 ovf", 32'(if1.err_overflow), 1);
        pulse_start();
        clear_mem();
        for (int i = 0; i < 5; i++) send(4'b0101, 5'(i), 1'b0);
        step();
        check("t4b writes", wr_cnt[1], 4);
        check("t4b ovf", 32'(if1.err_overflow), 1);

        // Back-to-back stream of five ops.
        pulse_start();
        clear_mem();
        op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_code = 4'b0010; op_operand = 5'(i + 1);
            step();
        end
        op_valid = 1'b0;
        check("t5 writes", wr_cnt[0], 5);
        for (int i = 0; i < 5; i++) check($sformatf("t5 mem%0d", i), mem[0][i], 32'h040 + i + 1);

        // Start colliding with a valid op.
        send(4'b0011, 5'b00001, 1'b0);
        clear_mem();
        start = 1'b1; op_valid = 1'b1; op_code = 4'b1000; op_operand = 5'b00111;
        step();
        start = 1'b0; op_valid = 1'b0;
        send(4'b1001, 5'b00101, 1'b0);
        check("t6 mem0", mem[0][0], 32'h125);
        check("t6 writes", wr_cnt[0], 1);
        check("t6 len", 32'(if0.prog_len), 1);

        // Asynchronous reset while a write strobe is high.
        send(4'b1100, 5'b00010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7 we", 32'(if0.imem_we), 0);
        check("t7 len", 32'(if0.prog_len), 0);
        check("t7 addr", 32'(if0.imem_addr), 0);
        check("t7 wdata", 32'(if0.imem_wdata), 0);
        check("t7 ready", 32'(if0.op_ready), 0);
        check("t7 d1 len", 32'(if1.prog_len), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic.
        clear_mem();
        pulse_start();
        for (int i = 0; i < 600; i++) begin
            start      = ($urandom % 20) == 0;
            op_valid   = ($urandom % 4) != 0;
            op_code    = 4'($urandom);
            op_operand = 5'($urandom);
            if (($urandom % 4) != 0) op_operand[4] = 1'b0;
            if (($urandom % 3) == 0 && op_code == 4'd11) op_operand = 5'd0;
            op_last    = ($urandom % 8) == 0;
            step();
        end
        start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
